// File: rtl/axil_apb_bridge_mux_if.sv
// Bus bundles for axil_apb_bridge_mux.
//   axil_lite_if : AXI-Lite channel set (master = initiator, slave = bridge)
//   apb_bus_if   : shared APB request bus with per-slave select/response lines
//                  (master = bridge, slave = peripherals)
interface axil_lite_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic [AW-1:0]   awaddr;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [AW-1:0]   araddr;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

interface apb_bus_if #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int NUM_SLV = 2
) ();
    logic [AW-1:0]         paddr;
    logic [2:0]            pprot;
    logic                  pwrite;
    logic [DW-1:0]         pwdata;
    logic [DW/8-1:0]       pstrb;
    logic                  penable;
    logic [NUM_SLV-1:0]    psel;
    logic [NUM_SLV-1:0]    pready;
    logic [NUM_SLV-1:0]    pslverr;
    logic [NUM_SLV*DW-1:0] prdata;

    modport master (
        output paddr, pprot, pwrite, pwdata, pstrb, penable, psel,
        input  pready, pslverr, prdata
    );

    modport slave (
        input  paddr, pprot, pwrite, pwdata, pstrb, penable, psel,
        output pready, pslverr, prdata
    );
endinterface

// File: rtl/axil_apb_bridge_mux.sv
// AXI-Lite to APB bridge with an address-decoded APB slave multiplexer.
// One transaction at a time through IDLE -> SETUP -> ACCESS -> RESP; decode
// misses go straight from IDLE to RESP with DECERR. Read/write collisions are
// arbitrated so the type not served last wins (read after reset).
// Optional feature: define AXIL_APB_TIMEOUT_EN to abort an ACCESS phase that
// sees no pready within TIMEOUT_CYC cycles and answer SLVERR.
module axil_apb_bridge_mux #(
    parameter int                             AXI_LITE_AW = 32,
    parameter int                             AXI_LITE_DW = 32,
    parameter int                             NUM_SLV     = 2,
    parameter logic [NUM_SLV*AXI_LITE_AW-1:0] SLV_BA      = {32'h0004_1000, 32'h0004_0000},
    parameter logic [AXI_LITE_AW-1:0]         SLV_SIZE    = 32'h1000,
    parameter int                             TIMEOUT_CYC = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    axil_lite_if.slave axi,
    apb_bus_if.master  apb
);

    localparam int SW = AXI_LITE_DW / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [AXI_LITE_AW-1:0]  paddr_q, paddr_d;
    logic [2:0]              pprot_q, pprot_d;
    logic                    pwrite_q, pwrite_d;
    logic [AXI_LITE_DW-1:0]  pwdata_q, pwdata_d;
    logic [SW-1:0]           pstrb_q, pstrb_d;
    logic [NUM_SLV-1:0]      slv_oh_q, slv_oh_d;
    logic                    is_wr_q, is_wr_d;
    logic                    prefer_wr_q, prefer_wr_d;
    logic [1:0]              resp_q, resp_d;
    logic [AXI_LITE_DW-1:0]  rdata_q, rdata_d;
`ifdef AXIL_APB_TIMEOUT_EN
    logic [15:0]             tmo_q, tmo_d;
`endif

    logic                    wr_pend;
    logic                    rd_pend;
    logic                    grant_wr;
    logic                    grant_rd;
    logic [AXI_LITE_AW-1:0]  req_addr;
    logic [NUM_SLV-1:0]      hit;
    logic [NUM_SLV-1:0]      hit_oh;
    logic [NUM_SLV-1:0]      sel_ready_v;
    logic [NUM_SLV-1:0]      sel_err_v;
    logic [AXI_LITE_DW-1:0]  rdata_masked [NUM_SLV];
    logic [AXI_LITE_DW-1:0]  sel_rdata;
    logic                    sel_ready;
    logic                    sel_err;

    // Arbitrate between a complete write (AW and W together) and a read.
    always_comb begin
        wr_pend  = axi.awvalid && axi.wvalid;
        rd_pend  = axi.arvalid;
        grant_wr = wr_pend && (!rd_pend || prefer_wr_q);
        grant_rd = rd_pend && !grant_wr;
        req_addr = grant_wr ? axi.awaddr : axi.araddr;
    end

    // Per-slave range decode and response masking by the latched select.
    // The range compare is one bit wider so a region ending at the top of the
    // address space does not wrap.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLV; gi++) begin : g_slv
            logic [AXI_LITE_AW:0] base_ext;
            logic [AXI_LITE_AW:0] limit_ext;
            logic [AXI_LITE_AW:0] addr_ext;

            assign base_ext         = {1'b0, SLV_BA[gi*AXI_LITE_AW +: AXI_LITE_AW]};
            assign limit_ext        = base_ext + {1'b0, SLV_SIZE};
            assign addr_ext         = {1'b0, req_addr};
            assign hit[gi]          = (addr_ext >= base_ext) && (addr_ext < limit_ext);
            assign rdata_masked[gi] = apb.prdata[gi*AXI_LITE_DW +: AXI_LITE_DW]
                                      & {AXI_LITE_DW{slv_oh_q[gi]}};
            assign sel_ready_v[gi]  = apb.pready[gi] & slv_oh_q[gi];
            assign sel_err_v[gi]    = apb.pslverr[gi] & slv_oh_q[gi];
        end
    endgenerate

    // Lowest-index hit wins when regions overlap.
    always_comb begin
        logic found;
        found  = 1'b0;
        hit_oh = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (hit[i] && !found) begin
                hit_oh[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    // Collapse the selected slave's response; slv_oh_q is one-hot or zero.
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            sel_rdata = sel_rdata | rdata_masked[i];
        end
        sel_ready = |sel_ready_v;
        sel_err   = |sel_err_v;
    end

    // Next-state and datapath update for the transaction FSM.
    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pprot_d     = pprot_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        slv_oh_d    = slv_oh_q;
        is_wr_d     = is_wr_q;
        prefer_wr_d = prefer_wr_q;
        resp_d      = resp_q;
        rdata_d     = rdata_q;
`ifdef AXIL_APB_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_wr || grant_rd) begin
                    is_wr_d     = grant_wr;
                    prefer_wr_d = !grant_wr;
                    if (|hit_oh) begin
                        // APB request fields are frozen here until RESP.
                        slv_oh_d = hit_oh;
                        paddr_d  = req_addr;
                        pprot_d  = grant_wr ? axi.awprot : axi.arprot;
                        pwrite_d = grant_wr;
                        pwdata_d = grant_wr ? axi.wdata : '0;
                        pstrb_d  = grant_wr ? axi.wstrb : '0;
                        state_d  = ST_SETUP;
                    end else begin
                        // Miss: no APB cycle, answer DECERR next cycle.
                        slv_oh_d = '0;
                        resp_d   = 2'b11;
                        rdata_d  = '0;
                        state_d  = ST_RESP;
                    end
                end
            end
            ST_SETUP: begin
`ifdef AXIL_APB_TIMEOUT_EN
                tmo_d   = '0;
`endif
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (sel_ready) begin
                    resp_d  = sel_err ? 2'b10 : 2'b00;
                    rdata_d = is_wr_q ? '0 : sel_rdata;
                    state_d = ST_RESP;
                end
`ifdef AXIL_APB_TIMEOUT_EN
                else if (tmo_q == 16'(TIMEOUT_CYC - 1)) begin
                    resp_d  = 2'b10;
                    rdata_d = '0;
                    state_d = ST_RESP;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
`endif
            end
            ST_RESP: begin
                if (is_wr_q ? axi.bready : axi.rready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            paddr_q     <= '0;
            pprot_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            slv_oh_q    <= '0;
            is_wr_q     <= 1'b0;
            prefer_wr_q <= 1'b0;
            resp_q      <= '0;
            rdata_q     <= '0;
`ifdef AXIL_APB_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pprot_q     <= pprot_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            slv_oh_q    <= slv_oh_d;
            is_wr_q     <= is_wr_d;
            prefer_wr_q <= prefer_wr_d;
            resp_q      <= resp_d;
            rdata_q     <= rdata_d;
`ifdef AXIL_APB_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    // Ready strobes are combinational in IDLE and forced low while in reset.
    assign axi.awready = rst_ni && (state_q == ST_IDLE) && grant_wr;
    assign axi.wready  = rst_ni && (state_q == ST_IDLE) && grant_wr;
    assign axi.arready = rst_ni && (state_q == ST_IDLE) && grant_rd;

    assign axi.bvalid  = (state_q == ST_RESP) && is_wr_q;
    assign axi.rvalid  = (state_q == ST_RESP) && !is_wr_q;
    assign axi.bresp   = resp_q;
    assign axi.rresp   = resp_q;
    assign axi.rdata   = rdata_q;

    assign apb.paddr   = paddr_q;
    assign apb.pprot   = pprot_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.pwdata  = pwdata_q;
    assign apb.pstrb   = pstrb_q;
    assign apb.penable = (state_q == ST_ACCESS);
    assign apb.psel    = ((state_q == ST_SETUP) || (state_q == ST_ACCESS)) ? slv_oh_q : '0;

endmodule

// File: tb/tb_axil_apb_bridge_mux.sv
// Directed bench for axil_apb_bridge_mux with a scoreboard of expected
// responses and a small behavioural APB slave with per-slave wait states.
module tb_axil_apb_bridge_mux;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axil_lite_if #(.AW(AW), .DW(DW)) axi ();
    apb_bus_if #(.AW(AW), .DW(DW), .NUM_SLV(NS)) apb ();

    axil_apb_bridge_mux #(
        .AXI_LITE_AW (AW),
        .AXI_LITE_DW (DW),
        .NUM_SLV     (NS),
        .SLV_BA      ({32'h0004_1000, 32'h0004_0000}),
        .SLV_SIZE    (32'h1000),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .axi    (axi),
        .apb    (apb)
    );

    typedef struct {
        bit            wr;
        logic [1:0]    resp;
        logic [DW-1:0] data;
        logic [NS-1:0] psel;
    } exp_t;

    exp_t sb [$];
    int checks = 0;
    int failures = 0;

    // APB slave model configuration
    int            wait_cfg [NS];
    logic [DW-1:0] rdata_cfg [NS];
    logic [NS-1:0] err_cfg;
    int            acc_cnt = 0;

    // Observations gathered while waiting for a response
    int            lat_g;
    int            pen_g;
    logic [NS-1:0] psel_g;
    bit            stable_g;
    bit            have_g;
    logic [AW-1:0] paddr_g;
    logic [DW-1:0] pwdata_g;
    logic [3:0]    pstrb_g;
    logic          pwrite_g;

    always_comb begin
        apb.pready  = '0;
        apb.prdata  = '0;
        apb.pslverr = err_cfg;
        for (int i = 0; i < NS; i++) begin
            apb.pready[i]          = apb.psel[i] && apb.penable && (acc_cnt >= wait_cfg[i]);
            apb.prdata[i*DW +: DW] = rdata_cfg[i];
        end
    end

    always @(posedge clk) begin
        if (apb.penable && !(|(apb.pready & apb.psel))) acc_cnt <= acc_cnt + 1;
        else                                            acc_cnt <= 0;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input bit wr, input logic [1:0] resp, input logic [DW-1:0] data,
                            input logic [NS-1:0] psel);
        exp_t e;
        e.wr = wr; e.resp = resp; e.data = data; e.psel = psel;
        sb.push_back(e);
    endtask

    // Drive one request, wait for its handshake, then drop its own valids.
    task automatic issue(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input bit push, input logic [1:0] eresp, input logic [DW-1:0] edata,
                         input logic [NS-1:0] epsel);
        int n;
        n = 0;
        if (wr) begin
            axi.awaddr = addr; axi.wdata = data; axi.wstrb = 4'hF;
            axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        end else begin
            axi.araddr = addr; axi.arvalid = 1'b1;
        end
        #1;
        while (!(wr ? axi.awready : axi.arready) && n < 50) begin
            tick();
            n++;
        end
        check(wr ? "aw_w_accept" : "ar_accept",
              wr ? {axi.awready, axi.wready} : {axi.arready, 1'b1}, 2'b11);
        if (push) push_exp(wr, eresp, edata, epsel);
        tick();
        if (wr) begin axi.awvalid = 1'b0; axi.wvalid = 1'b0; end
        else    axi.arvalid = 1'b0;
    endtask

    // Wait for bvalid/rvalid, compare with the scoreboard head, optionally
    // stall the response for 'hold' cycles, then complete the handshake.
    task automatic wait_resp(input int max_cyc, input int hold);
        exp_t          e;
        logic [1:0]    v0;
        logic [1:0]    r0;
        logic [DW-1:0] d0;
        lat_g = 1; pen_g = 0; psel_g = '0; stable_g = 1'b1; have_g = 1'b0;
        while (!(axi.bvalid || axi.rvalid) && lat_g < max_cyc) begin
            psel_g = psel_g | apb.psel;
            if (apb.psel != '0) begin
                if (have_g && ({apb.paddr, apb.pwdata, apb.pstrb, apb.pwrite} !==
                               {paddr_g, pwdata_g, pstrb_g, pwrite_g})) stable_g = 1'b0;
                paddr_g = apb.paddr; pwdata_g = apb.pwdata;
                pstrb_g = apb.pstrb; pwrite_g = apb.pwrite;
                have_g  = 1'b1;
            end
            if (apb.penable) pen_g++;
            tick();
            lat_g++;
        end
        check("resp_valid", axi.bvalid || axi.rvalid, 1);
        check("apb_idle_in_resp", {apb.psel, apb.penable}, 0);
        check("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("resp_kind", {axi.bvalid, axi.rvalid}, e.wr ? 2'b10 : 2'b01);
            check("resp_code", e.wr ? axi.bresp : axi.rresp, e.resp);
            if (!e.wr) check("rdata", axi.rdata, e.data);
            check("psel_seen", psel_g, e.psel);
            check("apb_stable", stable_g, 1);
        end
        v0 = {axi.bvalid, axi.rvalid};
        r0 = axi.bvalid ? axi.bresp : axi.rresp;
        d0 = axi.rdata;
        for (int k = 0; k < hold; k++) begin
            tick();
            check("hold_valid", {axi.bvalid, axi.rvalid}, v0);
            check("hold_payload", {(axi.bvalid ? axi.bresp : axi.rresp), axi.rdata}, {r0, d0});
        end
        axi.bready = 1'b1; axi.rready = 1'b1;
        tick();
        axi.bready = 1'b0; axi.rready = 1'b0;
        check("valid_drop", {axi.bvalid, axi.rvalid}, 0);
    endtask

    initial begin
        int  n;
        bit  exp_wr;
        axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
        axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.bready = 1'b0;
        axi.araddr = 32'h0004_0000; axi.arprot = '0; axi.arvalid = 1'b1; axi.rready = 1'b0;
        wait_cfg[0] = 0; wait_cfg[1] = 0;
        rdata_cfg[0] = 32'h1122_3344; rdata_cfg[1] = 32'h5566_7788;
        err_cfg = '0;

        // Reset: everything low, arready held off despite a pending read
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_psel_penable", {apb.psel, apb.penable}, 0);
        check("rst_readies", {axi.awready, axi.wready, axi.arready}, 0);
        check("rst_valids", {axi.bvalid, axi.rvalid}, 0);
        check("rst_resp_rdata", {axi.bresp, axi.rresp, axi.rdata}, 0);
        check("rst_apb_bus", {apb.paddr, apb.pwdata, apb.pstrb, apb.pwrite}, 0);
        axi.arvalid = 1'b0;
        rst_n = 1'b1;
        tick();

        // Simultaneous write/read to slave 0, twice: read, write, read, write
        for (int rep = 0; rep < 2; rep++) begin
            axi.awaddr = 32'h0004_0020; axi.wdata = 32'hCAFE_0000 + rep; axi.wstrb = 4'hF;
            axi.awvalid = 1'b1; axi.wvalid = 1'b1;
            axi.araddr = 32'h0004_0024; axi.arvalid = 1'b1;
            #1;
            for (int k = 0; k < 2; k++) begin
                exp_wr = (k == 1);
                n = 0;
                while (!(axi.awready || axi.arready) && n < 50) begin tick(); n++; end
                check("order_is_write", axi.awready, exp_wr);
                check("order_single_ready", axi.awready ^ axi.arready, 1);
                push_exp(exp_wr, 2'b00, rdata_cfg[0], 2'b01);
                tick();
                if (exp_wr) begin axi.awvalid = 1'b0; axi.wvalid = 1'b0; end
                else        axi.arvalid = 1'b0;
                wait_resp(20, 0);
            end
        end

        // Write to slave 1, immediate pready, response stalled 2 cycles
        issue(1'b1, 32'h0004_1008, 32'hA5A5_1234, 1'b1, 2'b00, '0, 2'b10);
        wait_resp(20, 2);
        check("wr_latency", lat_g, 3);
        check("wr_access_cycles", pen_g, 1);
        check("wr_paddr", paddr_g, 32'h0004_1008);
        check("wr_pwdata", pwdata_g, 32'hA5A5_1234);
        check("wr_pstrb_pwrite", {pstrb_g, pwrite_g}, 5'h1F);

        // Read from slave 0 with four wait states
        wait_cfg[0] = 4;
        issue(1'b0, 32'h0004_0004, '0, 1'b1, 2'b00, 32'h1122_3344, 2'b01);
        wait_resp(30, 0);
        check("rd_latency", lat_g, 3 + 4);
        check("rd_access_cycles", pen_g, 1 + 4);
        check("rd_pstrb_pwrite", {pstrb_g, pwrite_g}, 5'h00);
        check("rd_paddr", paddr_g, 32'h0004_0004);
        wait_cfg[0] = 0;

        // Decode miss: DECERR in the cycle after acceptance, no APB select
        issue(1'b0, 32'h0005_0000, '0, 1'b1, 2'b11, '0, 2'b00);
        wait_resp(20, 1);
        check("miss_latency", lat_g, 1);

        // Region boundaries and slave errors
        issue(1'b0, 32'h0004_0FFC, '0, 1'b1, 2'b00, 32'h1122_3344, 2'b01);
        wait_resp(20, 0);
        issue(1'b0, 32'h0004_1FFC, '0, 1'b1, 2'b00, 32'h5566_7788, 2'b10);
        wait_resp(20, 0);
        issue(1'b1, 32'h0004_2000, 32'h1, 1'b1, 2'b11, '0, 2'b00);
        wait_resp(20, 0);
        issue(1'b0, 32'h0003_FFFC, '0, 1'b1, 2'b11, '0, 2'b00);
        wait_resp(20, 0);
        err_cfg = 2'b01;
        issue(1'b1, 32'h0004_0000, 32'h2, 1'b1, 2'b10, '0, 2'b01);
        wait_resp(20, 0);
        issue(1'b0, 32'h0004_0008, '0, 1'b1, 2'b10, 32'h1122_3344, 2'b01);
        wait_resp(20, 0);
        err_cfg = 2'b00;

        // Slave that never answers
        wait_cfg[1] = 1000;
`ifdef AXIL_APB_TIMEOUT_EN
        issue(1'b1, 32'h0004_1010, 32'h3, 1'b1, 2'b10, '0, 2'b10);
        wait_resp(60, 0);
        check("tmo_access_cycles", pen_g, 16);
        check("tmo_latency", lat_g, 18);
`else
        issue(1'b1, 32'h0004_1010, 32'h3, 1'b1, 2'b00, '0, 2'b10);
        repeat (100) tick();
        check("stall_still_access", {apb.psel, apb.penable}, 3'b101);
        check("stall_no_bvalid", axi.bvalid, 0);
        wait_cfg[1] = 0;
        #1;
        wait_resp(10, 0);
`endif
        wait_cfg[1] = 0;

        // Reset during ACCESS aborts silently; a following write completes
        wait_cfg[0] = 1000;
        issue(1'b1, 32'h0004_0010, 32'h4, 1'b0, 2'b00, '0, 2'b00);
        tick();
        check("abort_in_access", {apb.psel, apb.penable}, 3'b011);
        rst_n = 1'b0;
        tick();
        check("abort_apb_low", {apb.psel, apb.penable}, 0);
        check("abort_no_valid", {axi.bvalid, axi.rvalid}, 0);
        rst_n = 1'b1;
        wait_cfg[0] = 0;
        tick();
        check("abort_still_no_valid", {axi.bvalid, axi.rvalid}, 0);
        issue(1'b1, 32'h0004_0014, 32'h5, 1'b1, 2'b00, '0, 2'b01);
        wait_resp(20, 0);
        check("post_rst_latency", lat_g, 3);

        // After a read the write wins a collision; reset returns priority to read
        issue(1'b0, 32'h0004_0000, '0, 1'b1, 2'b00, 32'h1122_3344, 2'b01);
        wait_resp(20, 0);
        axi.awaddr = 32'h0004_0000; axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        axi.araddr = 32'h0004_0000; axi.arvalid = 1'b1;
        #1;
        check("prio_after_read", {axi.awready, axi.arready}, 2'b10);
        axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.arvalid = 1'b1;
        #1;
        check("prio_after_reset", {axi.awready, axi.arready}, 2'b01);
        axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
        tick();

        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
